// File: rtl/display_mux_pkg.sv
// Shared types and helpers for the four-digit multiplexed display driver.
package display_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int NUM_DIGITS = 4;

  // True when nibbles idx..NUM_DIGITS-1 of v are all zero.
  function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] idx);
    logic z;
    z = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && v[4*k +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/display_mux_if.sv
// Bus between a display source and the multiplexer.
// load is a one-cycle qualifier with no ready: value is captured on every edge where load=1.
interface display_mux_if;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp;

  modport master (output value, load, blank_lz, dp_mask, input digit, an, dp);
  modport slave  (input value, load, blank_lz, dp_mask, output digit, an, dp);
endinterface

// File: rtl/display_mux_tick_gen.sv
// Slot prescaler: free-running mod-TICK_DIV counter with a wrap pulse on the last count.
module tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == LAST);
  assign cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_mux.sv
// Four-digit scan multiplexer with anode-off gap, leading-zero blanking and decimal points.
// Outputs are registered from next-state values so they move on the same edge as cnt/idx/state.
module display_mux
  import display_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic          clk,
  input  logic          reset,
  display_mux_if.slave  bus,
  output state_e        state_dbg_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt;
  logic          wrap;
  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;
  logic          dp_q, dp_d;
  logic          blank;

  tick_gen #(.TICK_DIV(TICK_DIV), .CW(CW)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= GAP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GAP:     if (cnt == GAP_LAST) state_d = SHOW;
      SHOW:    if (wrap)            state_d = GAP;
      default:                      state_d = GAP;
    endcase
  end

  assign idx_d    = wrap ? idx_q + 2'd1 : idx_q;
  assign shadow_d = bus.load ? bus.value : shadow_q;

  // Driven from shadow_d/idx_d so a load or slot change is visible on the capturing edge.
  always_comb begin
    blank   = bus.blank_lz && (idx_d != 2'd0) && upper_zero(shadow_d, idx_d);
    digit_d = shadow_d[4*idx_d +: 4];
    an_d    = 4'b1111;
    dp_d    = 1'b1;
    if (state_d == SHOW && !blank) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~bus.dp_mask[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'b1111;
      digit_q  <= 4'h0;
      dp_q     <= 1'b1;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      digit_q  <= digit_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.digit   = digit_q;
  assign bus.dp      = dp_q;
  assign state_dbg_o = state_q;

endmodule
